// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus types plus the arbiter state encoding and all-zero constants.
package cbus_arbiter_pkg;

    typedef logic [3:0] cbus_len_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        cbus_len_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    localparam cbus_req_t  CBUS_REQ_ZERO  = '0;
    localparam cbus_resp_t CBUS_RESP_ZERO = '0;

endpackage

// File: rtl/cbus_arbiter_if.sv
// Requester-side and bus-side cache-bus signals of the arbiter, bundled as one interface.
interface cbus_arbiter_if
    import cbus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) ();

    cbus_req_t  [NUM_REQ-1:0] ireqs;
    cbus_resp_t [NUM_REQ-1:0] iresps;
    cbus_req_t                oreq;
    cbus_resp_t               oresp;

    // Environment view: drives requests and the shared-bus response.
    modport master (
        output ireqs,
        input  iresps,
        input  oreq,
        output oresp
    );

    // Arbiter view.
    modport slave (
        input  ireqs,
        output iresps,
        output oreq,
        input  oresp
    );

endinterface

// File: rtl/cbus_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set bit strictly after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int unsigned W = $clog2(N);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            logic [W-1:0] cand;
            cand = W'((32'(ptr) + k) % N);
            if (!any && valid[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Cache-bus arbiter: grants whole transactions (bursts included) to one requester at a time.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    cbus_arbiter_if.slave  bus
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    arb_state_t         state;
    logic [IW-1:0]      sel;
    logic [IW-1:0]      last_sel;
    logic [IW-1:0]      pick_ptr;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] req_valid;
    logic               granted_valid;

    always_comb begin
        req_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = bus.ireqs[i].valid;
        end
    end

    // Fixed priority is round-robin with the pointer pinned to the top index,
    // so the scan always starts at port 0.
    assign pick_ptr = ROUND_ROBIN ? last_sel : IW'(NUM_REQ - 1);

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .valid (req_valid),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= '0;
            last_sel <= IW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        sel   <= pick_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.oresp.ready && bus.oresp.last) begin
                        last_sel <= sel;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // oreq depends only on state/sel/ireqs; oresp reaches iresps as a pure pass-through.
    always_comb begin
        bus.oreq      = CBUS_REQ_ZERO;
        bus.iresps    = '0;
        granted_valid = 1'b0;
        if (state == BUSY) begin
            bus.oreq         = bus.ireqs[sel];
            bus.iresps[sel]  = bus.oresp;
            granted_valid    = bus.ireqs[sel].valid;
        end
    end

    // A granted requester must hold valid until it has seen ready && last.
    a_hold_valid: assert property (
        @(posedge clk) disable iff (reset) (state == BUSY) |-> granted_valid
    );

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scoreboard bench for cbus_arbiter: round-robin instance plus a fixed-priority instance.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int unsigned N = 2;

    localparam logic [31:0] P0 = 32'h1FC0_0100;
    localparam logic [31:0] P1 = 32'h8000_0040;
    localparam logic [31:0] A0 = 32'h1FC0_0000;
    localparam logic [31:0] B1 = 32'h8000_1000;
    localparam logic [31:0] B2 = 32'h8000_2000;

    typedef struct {
        int unsigned port;
        logic [31:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cbus_arbiter_if #(.NUM_REQ(N)) bus ();
    cbus_arbiter_if #(.NUM_REQ(N)) fp_bus ();

    cbus_arbiter #(.NUM_REQ(N), .ROUND_ROBIN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    cbus_arbiter #(.NUM_REQ(N), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk   (clk),
        .reset (reset),
        .bus   (fp_bus.slave)
    );

    logic        auto_en = 1'b0;
    logic        fp_en   = 1'b0;
    cbus_resp_t  man_resp = '0;

    exp_t        exp_q[$];
    logic [31:0] fp_q[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned done_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cbus_req_t mkreq(input logic [31:0] addr, input cbus_len_t len, input logic wr);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.size     = 3'd2;
        r.addr     = addr;
        r.strobe   = wr ? 4'hF : 4'h0;
        r.data     = wr ? ~addr : 32'h0;
        r.len      = len;
        return r;
    endfunction

    function automatic cbus_resp_t mkresp(input logic rdy, input logic lst, input logic [31:0] d);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = d;
        return r;
    endfunction

    // Downstream responder: manual beats, or single-beat auto completion.
    always_comb begin
        bus.oresp = man_resp;
        if (auto_en) begin
            bus.oresp.ready = bus.oreq.valid;
            bus.oresp.last  = 1'b1;
            bus.oresp.data  = bus.oreq.addr ^ 32'h5A5A_0000;
        end
    end

    always_comb begin
        fp_bus.ireqs       = fp_en ? bus.ireqs : '0;
        fp_bus.oresp       = '0;
        fp_bus.oresp.ready = fp_bus.oreq.valid;
        fp_bus.oresp.last  = 1'b1;
        fp_bus.oresp.data  = fp_bus.oreq.addr;
    end

    logic        in_txn = 1'b0;
    logic        prev_done = 1'b0;
    int unsigned cur_port = 0;
    exp_t        e;

    always @(negedge clk) begin
        if (reset) begin
            in_txn    = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) check_eq("bubble", 64'(bus.oreq.valid), 64'(0));
            prev_done = 1'b0;
            if (!in_txn && bus.oreq.valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_grant", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("grant_addr", 64'(bus.oreq.addr), 64'(e.addr));
                    cur_port = e.port;
                    in_txn   = 1'b1;
                end
            end
            if (in_txn) begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (j == cur_port) check_eq("fwd", 64'(bus.iresps[j]), 64'(bus.oresp));
                    else               check_eq("leak", 64'(bus.iresps[j]), 64'(0));
                end
                if (bus.oresp.ready && bus.oresp.last) begin
                    in_txn    = 1'b0;
                    prev_done = 1'b1;
                    done_cnt++;
                end
            end else begin
                for (int unsigned j = 0; j < N; j++) begin
                    check_eq("idle_resp", 64'(bus.iresps[j]), 64'(0));
                end
                check_eq("idle_req", 64'(bus.oreq != CBUS_REQ_ZERO), 64'(0));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && fp_bus.oreq.valid) begin
            if (fp_q.size() == 0) check_eq("fp_unexpected", 64'(fp_q.size()), 64'(1));
            else                  check_eq("fp_grant_addr", 64'(fp_bus.oreq.addr), 64'(fp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        int unsigned budget;

        bus.ireqs = '0;
        reset = 1'b1;
        repeat (3) tick();
        check_eq("rst_oreq", 64'(bus.oreq), 64'(0));
        check_eq("rst_iresp0", 64'(bus.iresps[0]), 64'(0));
        check_eq("rst_iresp1", 64'(bus.iresps[1]), 64'(0));
        reset = 1'b0;
        tick();

        // Contention from the reset pointer: port 0 first, port 1 after the bubble.
        bus.ireqs[0] = mkreq(P0, 4'd0, 1'b0);
        bus.ireqs[1] = mkreq(P1, 4'd1, 1'b1);
        exp_q.push_back('{port: 0, addr: P0});
        exp_q.push_back('{port: 1, addr: P1});
        tick();
        check_eq("c_first", 64'(bus.oreq.addr), 64'(P0));
        man_resp = mkresp(1'b1, 1'b1, 32'h1111_0000);
        tick();
        man_resp = '0;
        bus.ireqs[0] = '0;
        check_eq("c_gap", 64'(bus.oreq.valid), 64'(0));
        tick();
        check_eq("c_second_valid", 64'(bus.oreq.valid), 64'(1));
        check_eq("c_second_addr", 64'(bus.oreq.addr), 64'(P1));
        man_resp = mkresp(1'b1, 1'b0, 32'h2222_0000);
        tick();
        man_resp = mkresp(1'b1, 1'b1, 32'h2222_0001);
        tick();
        man_resp = '0;
        bus.ireqs[1] = '0;
        tick();

        // Fairness: both hold valid for six single-beat transactions.
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back((i % 2 == 0) ? '{port: 0, addr: P0} : '{port: 1, addr: P1});
            fp_q.push_back(P0);
        end
        base = done_cnt;
        budget = 40;
        bus.ireqs[0] = mkreq(P0, 4'd0, 1'b0);
        bus.ireqs[1] = mkreq(P1, 4'd0, 1'b0);
        auto_en = 1'b1;
        fp_en   = 1'b1;
        while (done_cnt < base + 6 && budget > 0) begin
            tick();
            budget--;
        end
        bus.ireqs = '0;
        auto_en = 1'b0;
        fp_en   = 1'b0;
        check_eq("rr_done", 64'(done_cnt - base), 64'(6));
        check_eq("rr_sb_empty", 64'(exp_q.size()), 64'(0));
        check_eq("fp_sb_empty", 64'(fp_q.size()), 64'(0));
        tick();

        // Single read.
        bus.ireqs[0] = mkreq(A0, 4'd0, 1'b0);
        exp_q.push_back('{port: 0, addr: A0});
        tick();
        check_eq("t1_valid", 64'(bus.oreq.valid), 64'(1));
        check_eq("t1_addr", 64'(bus.oreq.addr), 64'(A0));
        tick();
        tick();
        man_resp = mkresp(1'b1, 1'b1, 32'h3C1D_BFC0);
        #1;
        check_eq("t1_iresp0", 64'(bus.iresps[0]), 64'({1'b1, 1'b1, 32'h3C1D_BFC0}));
        check_eq("t1_iresp1", 64'(bus.iresps[1]), 64'(0));
        tick();
        check_eq("t1_idle", 64'(bus.oreq.valid), 64'(0));
        bus.ireqs[0] = '0;
        man_resp = '0;
        tick();

        // Burst lock: port 1 four beats, port 0 joins at beat 2.
        bus.ireqs[1] = mkreq(B1, 4'd3, 1'b0);
        exp_q.push_back('{port: 1, addr: B1});
        exp_q.push_back('{port: 0, addr: A0});
        tick();
        for (int k = 0; k < 4; k++) begin
            man_resp = mkresp(1'b1, (k == 3), 32'hD000_0000 + 32'(k));
            if (k == 1) bus.ireqs[0] = mkreq(A0, 4'd0, 1'b0);
            #1;
            check_eq("burst_addr", 64'(bus.oreq.addr), 64'(B1));
            check_eq("burst_hold_p0", 64'(bus.iresps[0]), 64'(0));
            tick();
        end
        man_resp = '0;
        bus.ireqs[1] = '0;
        check_eq("burst_gap", 64'(bus.oreq.valid), 64'(0));
        tick();
        check_eq("burst_next", 64'(bus.oreq.addr), 64'(A0));
        man_resp = mkresp(1'b1, 1'b1, 32'h0BAD_F00D);
        tick();
        man_resp = '0;
        bus.ireqs[0] = '0;
        tick();

        // Reset during beat 2 of a 4-beat burst.
        bus.ireqs[1] = mkreq(B2, 4'd3, 1'b0);
        exp_q.push_back('{port: 1, addr: B2});
        tick();
        man_resp = mkresp(1'b1, 1'b0, 32'hE000_0000);
        tick();
        man_resp = mkresp(1'b1, 1'b0, 32'hE000_0001);
        reset = 1'b1;
        tick();
        check_eq("mid_rst_valid", 64'(bus.oreq.valid), 64'(0));
        check_eq("mid_rst_iresp0", 64'(bus.iresps[0]), 64'(0));
        check_eq("mid_rst_iresp1", 64'(bus.iresps[1]), 64'(0));
        reset = 1'b0;
        bus.ireqs[1] = '0;
        man_resp = '0;
        tick();
        bus.ireqs[0] = mkreq(A0, 4'd0, 1'b0);
        exp_q.push_back('{port: 0, addr: A0});
        tick();
        check_eq("post_rst_valid", 64'(bus.oreq.valid), 64'(1));
        check_eq("post_rst_addr", 64'(bus.oreq.addr), 64'(A0));
        man_resp = mkresp(1'b1, 1'b1, 32'h1234_5678);
        tick();
        man_resp = '0;
        bus.ireqs[0] = '0;
        tick();

        // Spurious response while idle.
        man_resp = mkresp(1'b1, 1'b1, 32'hDEAD_BEEF);
        #1;
        check_eq("spur_iresp0", 64'(bus.iresps[0]), 64'(0));
        check_eq("spur_iresp1", 64'(bus.iresps[1]), 64'(0));
        tick();
        check_eq("spur_state", 64'(bus.oreq.valid), 64'(0));
        man_resp = '0;
        tick();
        tick();

        check_eq("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
